// File: rtl/board_dealer.sv
// Deals a shuffled 8-pair card layout for the 16-cell memory board.
// Fisher-Yates driven by a free-running LFSR, streamed out as cell writes, then committed.
module board_dealer #(
  parameter int unsigned NCARDS       = 16,
  parameter int unsigned LABEL_W      = 4,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        seed_load,
  input  logic [15:0]                 seed,
  output logic                        busy,
  output logic                        done,
  output logic                        wr_en,
  output logic [3:0]                  wr_idx,
  output logic [LABEL_W-1:0]          wr_label,
  output logic [NCARDS*LABEL_W-1:0]   labels
);

  // Cell 0 sits in the low nibble.
  localparam logic [63:0] DefaultLayout = 64'h2518_4736_8765_4231;

  typedef enum logic [2:0] {StIdle, StInit, StDraw, StSwap, StEmit, StCommit} state_e;

  state_e               state_q, state_d;
  logic [15:0]          lfsr_q;
  logic [3:0]           i_q, i_d;
  logic [3:0]           j_q, j_d;
  logic [3:0]           idx_q, idx_d;
  logic [3:0]           mask;
  logic [3:0]           r;
  logic [LABEL_W-1:0]   work_q [NCARDS];

  function automatic logic [LABEL_W-1:0] default_label(input int unsigned k);
    return LABEL_W'(DefaultLayout[4*k +: 4]);
  endfunction

  // Free-running in every state, so the shuffle depends on when start arrives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_q <= DEFAULT_SEED;
    end else if (seed_load) begin
      lfsr_q <= (seed == 16'd0) ? DEFAULT_SEED : seed;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  always_comb begin
    if (i_q[3])      mask = 4'hF;
    else if (i_q[2]) mask = 4'h7;
    else if (i_q[1]) mask = 4'h3;
    else             mask = 4'h1;
  end

  assign r = lfsr_q[3:0] & mask;

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StInit;
      end
      StInit: begin
        i_d     = 4'(NCARDS - 1);
        state_d = StDraw;
      end
      StDraw: begin
        // Out-of-range draws are rejected rather than folded, keeping the shuffle unbiased.
        if (r <= i_q) begin
          j_d     = r;
          state_d = StSwap;
        end
      end
      StSwap: begin
        if (i_q == 4'd1) begin
          idx_d   = 4'd0;
          state_d = StEmit;
        end else begin
          i_d     = i_q - 4'd1;
          state_d = StDraw;
        end
      end
      StEmit: begin
        if (idx_q == 4'(NCARDS - 1)) state_d = StCommit;
        else                         idx_d   = idx_q + 4'd1;
      end
      StCommit: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      i_q     <= '0;
      j_q     <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      idx_q   <= idx_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCARDS; k++) work_q[k] <= default_label(k);
    end else if (state_q == StInit) begin
      for (int k = 0; k < NCARDS; k++) work_q[k] <= LABEL_W'((k >> 1) + 1);
    end else if (state_q == StSwap) begin
      work_q[i_q] <= work_q[j_q];
      work_q[j_q] <= work_q[i_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NCARDS; k++) labels[k*LABEL_W +: LABEL_W] <= default_label(k);
    end else if (state_q == StCommit) begin
      for (int k = 0; k < NCARDS; k++) labels[k*LABEL_W +: LABEL_W] <= work_q[k];
    end
  end

  always_comb begin
    busy     = (state_q == StInit) || (state_q == StDraw) ||
               (state_q == StSwap) || (state_q == StEmit);
    done     = (state_q == StCommit);
    wr_en    = (state_q == StEmit);
    wr_idx   = wr_en ? idx_q : 4'd0;
    wr_label = wr_en ? work_q[idx_q] : '0;
  end

endmodule

// File: tb/tb_board_dealer.sv
// Self-checking bench for board_dealer: a shadow LFSR plus a shuffle model predict every
// emitted write, the committed layout and the start-to-done latency of each deal.
module tb_board_dealer;

  localparam logic [15:0] DefSeed   = 16'hACE1;
  localparam logic [63:0] DefLayout = 64'h2518_4736_8765_4231;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        busy, done, wr_en;
  logic [3:0]  wr_idx, wr_label;
  logic [63:0] labels;

  int n_vec = 0;
  int n_bad = 0;

  logic [15:0] lf_m;
  logic [7:0]  sbq [$];

  always #5 clk = ~clk;

  board_dealer dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .seed_load (seed_load),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_label  (wr_label),
    .labels    (labels)
  );

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Shadow of the DUT LFSR, advanced from the same inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           lf_m <= DefSeed;
    else if (seed_load) lf_m <= (seed == 16'd0) ? DefSeed : seed;
    else                lf_m <= step(lf_m);
  end

  function automatic logic [3:0] msk(input int i);
    if (i >= 8) return 4'hF;
    if (i >= 4) return 4'h7;
    if (i >= 2) return 4'h3;
    return 4'h1;
  endfunction

  // lf_init is the LFSR value during the INIT cycle.
  function automatic void predict(input logic [15:0] lf_init, output logic [63:0] lay,
                                  output int draws, output int rej8);
    logic [3:0]  w [16];
    logic [15:0] lf;
    logic [3:0]  r, t;
    for (int k = 0; k < 16; k++) w[k] = 4'((k >> 1) + 1);
    lf    = step(lf_init);
    draws = 0;
    rej8  = 0;
    for (int i = 15; i >= 1; i--) begin
      r = lf[3:0] & msk(i); lf = step(lf); draws++;
      while (int'(r) > i) begin
        if (i == 8) rej8++;
        r = lf[3:0] & msk(i); lf = step(lf); draws++;
      end
      t = w[i]; w[i] = w[r]; w[r] = t;
      lf = step(lf);
    end
    for (int k = 0; k < 16; k++) lay[4*k +: 4] = w[k];
  endfunction

  function automatic bit pairs_ok(input logic [63:0] l);
    int cnt [16];
    for (int v = 0; v < 16; v++) cnt[v] = 0;
    for (int k = 0; k < 16; k++) cnt[l[4*k +: 4]]++;
    for (int v = 0; v < 16; v++)
      if (cnt[v] != ((v >= 1 && v <= 8) ? 2 : 0)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after COMMIT.
  task automatic run_deal(input bit do_seed, input logic [15:0] sd, input int ex1,
                          input int ex2, output logic [63:0] lay, output int lat_obs);
    logic [15:0] lf_init;
    logic [7:0]  e;
    int          draws, rej8, lat, nwr;
    bit          got;
    lf_init = do_seed ? ((sd == 16'd0) ? DefSeed : sd) : step(lf_m);
    predict(lf_init, lay, draws, rej8);
    for (int k = 0; k < 16; k++) sbq.push_back({4'(k), lay[4*k +: 4]});
    lat       = 33 + draws;
    lat_obs   = 0;
    start     = 1'b1;
    seed_load = do_seed;
    seed      = sd;
    @(negedge clk);
    start     = 1'b0;
    seed_load = 1'b0;
    got       = 1'b0;
    nwr       = 0;
    for (int cyc = 1; cyc <= 400 && !got; cyc++) begin
      if (cyc == 1) chk("busy_after_start", 64'(busy), 64'd1);
      if (wr_en) begin
        nwr++;
        e = (sbq.size() != 0) ? sbq.pop_front() : 8'hFF;
        chk("wr_idx", 64'(wr_idx), 64'(e[7:4]));
        chk("wr_label", 64'(wr_label), 64'(e[3:0]));
        chk("busy_in_emit", 64'(busy), 64'd1);
      end
      if (done) begin
        got     = 1'b1;
        lat_obs = cyc;
        chk("latency", 64'(cyc), 64'(lat));
        chk("latency_min", 64'(cyc >= 48), 64'd1);
        chk("wr_count", 64'(nwr), 64'd16);
        chk("busy_at_done", 64'(busy), 64'd0);
      end
      start = (cyc == ex1) || (cyc == ex2);
      if (!got) @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 64'(got), 64'd1);
    @(negedge clk);
    chk("done_single", 64'(done), 64'd0);
    chk("labels", labels, lay);
    chk("pairs", 64'(pairs_ok(labels)), 64'd1);
    sbq.delete();
  endtask

  initial begin
    logic [63:0] lay, lay_a, lay_b, tmp;
    logic [15:0] s;
    int          lat_obs, d, rj;
    bit          found, reached;

    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_idx", 64'(wr_idx), 64'd0);
    chk("rst_wr_label", 64'(wr_label), 64'd0);
    chk("rst_labels", labels, DefLayout);
    @(negedge clk);
    rst = 1'b1;

    // Reference deal: start three cycles after reset release.
    repeat (3) @(negedge clk);
    run_deal(1'b0, 16'd0, 0, 0, lay_a, lat_obs);

    // Zero seed reloads the default, so the same offset must reproduce the deal above.
    rst = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    seed_load = 1'b1;
    seed      = 16'd0;
    @(negedge clk);
    seed_load = 1'b0;
    chk("zero_seed_lfsr", 64'(dut.lfsr_q), 64'(DefSeed));
    repeat (3) @(negedge clk);
    run_deal(1'b0, 16'd0, 0, 0, lay_b, lat_obs);
    chk("zero_seed_same", lay_b, lay_a);

    // Seed 1 loaded ahead of start, then the same seed coincident with start.
    seed_load = 1'b1;
    seed      = 16'h0001;
    @(negedge clk);
    seed_load = 1'b0;
    run_deal(1'b0, 16'd0, 0, 0, lay, lat_obs);
    run_deal(1'b1, 16'h0001, 0, 0, lay, lat_obs);

    // Extra start pulses mid-deal must be ignored.
    run_deal(1'b0, 16'd0, 5, 20, lay, lat_obs);

    // Find a seed whose i=8 draw gets rejected at least once.
    found = 1'b0;
    s     = 16'd1;
    for (int n = 1; n < 65536 && !found; n++) begin
      predict(16'(n), tmp, d, rj);
      if (rj > 0) begin
        found = 1'b1;
        s     = 16'(n);
      end
    end
    run_deal(1'b1, s, 0, 0, lay, lat_obs);
    chk("reject_slower", 64'(lat_obs > 48), 64'd1);

    for (int n = 0; n < 200; n++) begin
      s = 16'($urandom);
      run_deal(1'b1, s, 0, 0, lay, lat_obs);
    end

    // Reset in the middle of EMIT.
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      if (wr_en && wr_idx == 4'd5) reached = 1'b1;
      else @(negedge clk);
    end
    chk("emit_reached", 64'(reached), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_wr_en", 64'(wr_en), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_wr_idx", 64'(wr_idx), 64'd0);
    chk("abort_labels", labels, DefLayout);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    run_deal(1'b0, 16'd0, 0, 0, lay, lat_obs);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
